// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bus bundle between the fetch stage and its neighbours.
//   D, W          program counter width / machine word width
//   imem_addr     fetch PC presented to the instruction memory
//   imem_rd       read strobe; imem_data returns the word one cycle later
//   imem_data     returned machine word
//   br_taken      redirect pulse from execute, br_target is the new PC
//   halt          stop fetching (program done)
//   instr         head-of-queue word, instr_pc its PC, instr_valid head valid
//   instr_ready   decode accepts the head word
//   halted        fetch stage has fully drained and stopped
// modport master: the fetch stage side; modport slave: memory/decode/execute side.
interface fetch_queue_if #(
    parameter int D = 10,
    parameter int W = 9
);
    logic [D-1:0] imem_addr;
    logic         imem_rd;
    logic [W-1:0] imem_data;
    logic         br_taken;
    logic [D-1:0] br_target;
    logic         halt;
    logic [W-1:0] instr;
    logic [D-1:0] instr_pc;
    logic         instr_valid;
    logic         instr_ready;
    logic         halted;

    modport master (
        output imem_addr, imem_rd, instr, instr_pc, instr_valid, halted,
        input  imem_data, br_taken, br_target, halt, instr_ready
    );

    modport slave (
        input  imem_addr, imem_rd, instr, instr_pc, instr_valid, halted,
        output imem_data, br_taken, br_target, halt, instr_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage between the PC/instruction-ROM pair and decode.
// Owns the PC, issues reads to a 1-cycle synchronous instruction memory, buffers the
// returned words with their PCs in a small FIFO and hands them to decode over a
// valid/ready handshake. A branch redirect flushes buffered and in-flight words.
// Ports:
//   clk    clock, all state on posedge
//   reset  synchronous, active-high
//   bus    fetch_queue_if.master (imem request/response, branch, halt, decode handshake)
//   perf_fetch_cnt / perf_flush_cnt  saturating 16-bit counters of popped words and
//                                    accepted redirects, present only when the
//                                    FETCH_PERF_EN macro is defined.
module fetch_queue #(
    parameter int D     = 10,
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input logic          clk,
    input logic          reset,
    fetch_queue_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]  perf_fetch_cnt,
    output logic [15:0]  perf_flush_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic [D-1:0] pc;
        logic [W-1:0] word;
    } entry_t;

    typedef logic [CW:0] occ_t;

    state_t        state_q, state_d;
    logic [D-1:0]  pc_q, pc_d;
    logic          inflight_q, inflight_d;
    logic [D-1:0]  inflight_pc_q, inflight_pc_d;
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] remain;
    logic [W-1:0]  instr_q, instr_d;
    logic [D-1:0]  instr_pc_q, instr_pc_d;

    logic          br_acc;
    logic          pop;
    logic          push;
    logic          issue;
    occ_t          occ;

    // Handshake and issue decisions for the current cycle. The occupancy sum counts
    // the in-flight slot and the pending push separately, so issue stops one word
    // early rather than risk a push into a full FIFO.
    always_comb begin
        br_acc = bus.br_taken && (state_q != HALTED);
        pop    = (count_q != '0) && bus.instr_ready;
        push   = inflight_q && !br_acc;
        occ    = occ_t'(count_q) + occ_t'(inflight_q) + occ_t'(push) - occ_t'(pop);
        issue  = !reset && (state_q == RUN) && !bus.halt && !br_acc
                 && (occ < occ_t'(DEPTH));
    end

    // Next-state logic for the PC, in-flight tag, FIFO and the registered head word.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? pc_q : inflight_pc_q;
        mem_d         = mem_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q + CW'(push) - CW'(pop);
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        remain        = count_q - CW'(pop);

        if (push) begin
            mem_d[tail_q] = '{pc: inflight_pc_q, word: bus.imem_data};
            tail_d        = tail_q + PW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end

        // The head word is kept in its own register so it holds its last value once
        // the queue empties; when the queue was about to empty, the new head is the
        // word being pushed this cycle.
        if (!br_acc && (count_d != '0)) begin
            if (remain != '0) begin
                instr_d    = mem_q[head_d].word;
                instr_pc_d = mem_q[head_d].pc;
            end else begin
                instr_d    = bus.imem_data;
                instr_pc_d = inflight_pc_q;
            end
        end

        // A redirect lets this cycle's pop complete, then empties the queue, squashes
        // the returning word and restarts fetch from the target.
        if (br_acc) begin
            pc_d    = bus.br_target;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (issue) begin
            pc_d = pc_q + D'(1);
        end

        case (state_q)
            RUN:     if (bus.halt) state_d = DRAIN;
            DRAIN:   if ((count_q == '0) && !inflight_q) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.imem_rd     = issue;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = (count_q != '0);
    assign bus.halted      = (state_q == HALTED);

`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetch_q, perf_fetch_d;
    logic [15:0] perf_flush_q, perf_flush_d;

    // Saturating event counters for popped words and accepted redirects.
    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_flush_d = perf_flush_q;
        if (pop && (perf_fetch_q != 16'hFFFF)) perf_fetch_d = perf_fetch_q + 16'd1;
        if (br_acc && (perf_flush_q != 16'hFFFF)) perf_flush_d = perf_flush_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_flush_cnt = perf_flush_q;
`endif
endmodule
